// File: rtl/wb_stage.sv
// wb_stage: writeback stage, r15 writes redirected to pc_write, retire counter; WB_FWD_EN adds forwarding ports
module wb_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              m_valid,
  input  logic              m_regwrite,
  input  logic              m_memtoreg,
  input  logic              m_byte,
  input  logic [ADDR_W-1:0] m_wa,
  input  logic [DATA_W-1:0] m_alu_result,
  input  logic [DATA_W-1:0] m_read_data,
`ifdef WB_FWD_EN
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic              fwd1,
  output logic              fwd2,
  output logic [DATA_W-1:0] fwd_data,
`endif
  output logic              we3,
  output logic [ADDR_W-1:0] wa3,
  output logic [DATA_W-1:0] wd3,
  output logic              pc_write,
  output logic [DATA_W-1:0] pc_target,
  output logic              wb_valid,
  output logic [CNT_W-1:0]  retire_count
);
  logic              valid, regwrite, memtoreg, byte_ld;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] alu_result, read_data, result;
  logic [1:0]        byte_off;
  logic              commit, is_r15;
  always_ff @(posedge clk) begin
    if (reset) begin
      valid      <= 1'b0;
      regwrite   <= 1'b0;
      memtoreg   <= 1'b0;
      byte_ld    <= 1'b0;
      wa         <= '0;
      alu_result <= '0;
      read_data  <= '0;
      byte_off   <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (!stall) begin
      valid      <= m_valid;
      regwrite   <= m_regwrite;
      memtoreg   <= m_memtoreg;
      byte_ld    <= m_byte;
      wa         <= m_wa;
      alu_result <= m_alu_result;
      read_data  <= m_read_data;
      byte_off   <= m_alu_result[1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) retire_count <= '0;
    else if (commit) retire_count <= retire_count + CNT_W'(1);
  end
  always_comb begin
    commit    = valid & ~stall;
    is_r15    = wa == '1;
    result    = !memtoreg ? alu_result :
                !byte_ld  ? read_data  :
                {{(DATA_W-8){1'b0}}, read_data[{byte_off, 3'b000} +: 8]};
    we3       = commit & regwrite & ~is_r15;
    pc_write  = commit & regwrite & is_r15;
    wa3       = wa;
    wd3       = result;
    pc_target = result;
    wb_valid  = valid;
  end
`ifdef WB_FWD_EN
  // r15 is never held in the register file, so it is never forwarded
  always_comb begin
    fwd1     = valid & regwrite & (wa == ra1) & (ra1 != '1);
    fwd2     = valid & regwrite & (wa == ra2) & (ra2 != '1);
    fwd_data = result;
  end
`endif
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: table vectors, hand sequences and random stimulus against a behavioural model of wb_stage
module tb_wb_stage;
  logic        clk = 1'b0;
  logic        reset, stall, flush, m_valid, m_regwrite, m_memtoreg, m_byte;
  logic [3:0]  m_wa;
  logic [31:0] m_alu_result, m_read_data;
  logic        we3, pc_write, wb_valid;
  logic [3:0]  wa3;
  logic [31:0] wd3, pc_target, retire_count;
`ifdef WB_FWD_EN
  logic [3:0]  ra1 = 4'd0, ra2 = 4'd0;
  logic        fwd1, fwd2;
  logic [31:0] fwd_data;
`endif
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  wb_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_regwrite(m_regwrite), .m_memtoreg(m_memtoreg), .m_byte(m_byte),
    .m_wa(m_wa), .m_alu_result(m_alu_result), .m_read_data(m_read_data),
`ifdef WB_FWD_EN
    .ra1(ra1), .ra2(ra2), .fwd1(fwd1), .fwd2(fwd2), .fwd_data(fwd_data),
`endif
    .we3(we3), .wa3(wa3), .wd3(wd3), .pc_write(pc_write), .pc_target(pc_target),
    .wb_valid(wb_valid), .retire_count(retire_count)
  );

  typedef struct {
    bit v, rw, mtr, byt;
    bit [3:0] wa;
    bit [31:0] alu, rd;
  } ins_t;

  typedef struct {
    bit v, rw, mtr, byt;
    bit [3:0] wa;
    bit [31:0] alu, rd;
    bit e_we, e_pcw, e_val;
    bit [31:0] e_wd;
    int unsigned e_cnt;
  } vec_t;

  ins_t st;
  int unsigned cnt = 0;
  vec_t vt[10];
  int unsigned base;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model_result();
    if (!st.mtr) return st.alu;
    if (!st.byt) return st.rd;
    return (st.rd / (32'd1 << (8 * st.alu[1:0]))) % 256;
  endfunction

  task automatic check_model();
    bit commit = st.v && !stall;
    bit r15 = st.wa == 4'd15;
    chk("we3", we3, 32'(commit && st.rw && !r15));
    chk("pc_write", pc_write, 32'(commit && st.rw && r15));
    chk("wa3", wa3, st.wa);
    chk("wd3", wd3, model_result());
    chk("pc_target", pc_target, model_result());
    chk("wb_valid", wb_valid, 32'(st.v));
    chk("retire_count", retire_count, cnt);
`ifdef WB_FWD_EN
    chk("fwd1", fwd1, 32'(st.v && st.rw && st.wa == ra1 && ra1 != 4'd15));
    chk("fwd2", fwd2, 32'(st.v && st.rw && st.wa == ra2 && ra2 != 4'd15));
    chk("fwd_data", fwd_data, model_result());
`endif
  endtask

  task automatic drive(bit r, bit s, bit f, bit v, bit rw, bit mtr, bit byt,
                       bit [3:0] wa, bit [31:0] alu, bit [31:0] rd);
    reset = r; stall = s; flush = f;
    m_valid = v; m_regwrite = rw; m_memtoreg = mtr; m_byte = byt;
    m_wa = wa; m_alu_result = alu; m_read_data = rd;
  endtask

  task automatic tick();
    #1 check_model();
    @(posedge clk);
    if (reset) begin
      st = '{default: 0};
      cnt = 0;
    end else begin
      if (st.v && !stall) cnt++;
      if (flush) st.v = 1'b0;
      else if (!stall) st = '{m_valid, m_regwrite, m_memtoreg, m_byte, m_wa, m_alu_result, m_read_data};
    end
    #1;
  endtask

  initial begin
    vt[0] = '{1, 1, 0, 0, 4'd3,  32'h12345678, 32'hAABBCCDD, 1, 0, 1, 32'h12345678, 0};
    vt[1] = '{1, 1, 1, 1, 4'd1,  32'h00000102, 32'hAABBCCDD, 1, 0, 1, 32'h000000BB, 1};
    vt[2] = '{1, 1, 1, 0, 4'd1,  32'h00000102, 32'hAABBCCDD, 1, 0, 1, 32'hAABBCCDD, 2};
    vt[3] = '{1, 1, 0, 0, 4'd15, 32'h00000080, 32'hAABBCCDD, 0, 1, 1, 32'h00000080, 3};
    vt[4] = '{1, 1, 1, 1, 4'd7,  32'h00000100, 32'hAABBCCDD, 1, 0, 1, 32'h000000DD, 4};
    vt[5] = '{1, 1, 1, 1, 4'd7,  32'h00000103, 32'hAABBCCDD, 1, 0, 1, 32'h000000AA, 5};
    vt[6] = '{1, 1, 1, 1, 4'd7,  32'h00000101, 32'hAABBCCDD, 1, 0, 1, 32'h000000CC, 6};
    vt[7] = '{0, 1, 0, 0, 4'd4,  32'h00000055, 32'hAABBCCDD, 0, 0, 0, 32'h00000055, 7};
    vt[8] = '{1, 0, 0, 0, 4'd2,  32'h00000099, 32'hAABBCCDD, 0, 0, 1, 32'h00000099, 7};
    vt[9] = '{1, 0, 0, 0, 4'd15, 32'h00000080, 32'hAABBCCDD, 0, 0, 1, 32'h00000080, 8};

    drive(1, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_we3", we3, 0);
    chk("rst_pc_write", pc_write, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wa3", wa3, 0);
    chk("rst_wd3", wd3, 0);
    chk("rst_pc_target", pc_target, 0);
    chk("rst_count", retire_count, 0);

    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 0, vt[i].v, vt[i].rw, vt[i].mtr, vt[i].byt, vt[i].wa, vt[i].alu, vt[i].rd);
      tick();
      chk($sformatf("vec%0d_we3", i), we3, 32'(vt[i].e_we));
      chk($sformatf("vec%0d_pc_write", i), pc_write, 32'(vt[i].e_pcw));
      chk($sformatf("vec%0d_wb_valid", i), wb_valid, 32'(vt[i].e_val));
      chk($sformatf("vec%0d_wa3", i), wa3, vt[i].wa);
      chk($sformatf("vec%0d_wd3", i), wd3, vt[i].e_wd);
      chk($sformatf("vec%0d_count", i), retire_count, vt[i].e_cnt);
    end

    drive(0, 0, 0, 1, 1, 0, 0, 4'd5, 32'h77, 32'd0);
    tick();
    base = cnt;
    chk("stall_base", base, 9);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 0, 1, 1, 0, 0, 4'd6, 32'h11, 32'd0);
      tick();
      chk("stall_we3", we3, 0);
      chk("stall_valid", wb_valid, 1);
      chk("stall_wd3", wd3, 32'h77);
      chk("stall_count", retire_count, base);
    end
    drive(0, 1, 1, 1, 1, 0, 0, 4'd6, 32'h11, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    #1;
    chk("sf_valid", wb_valid, 0);
    chk("sf_we3", we3, 0);
    chk("sf_count", retire_count, base);
    tick();
    chk("sf_count2", retire_count, base);

    drive(1, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 1, 1, 0, 0, 4'(i + 1), 32'(i + 16), 32'd0);
      tick();
    end
    chk("mid_count", retire_count, 5);
    chk("mid_valid", wb_valid, 1);
    drive(1, 0, 0, 1, 1, 0, 0, 4'd9, 32'h5A5A, 32'd0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 4'd0, 32'd0, 32'd0);
    #1;
    chk("mid_we3", we3, 0);
    chk("mid_pc_write", pc_write, 0);
    chk("mid_wb_valid", wb_valid, 0);
    chk("mid_wa3", wa3, 0);
    chk("mid_wd3", wd3, 0);
    chk("mid_count0", retire_count, 0);

`ifdef WB_FWD_EN
    drive(0, 0, 0, 1, 1, 0, 0, 4'd4, 32'hCAFE, 32'd0);
    tick();
    ra1 = 4'd4;
    ra2 = 4'd15;
    #1;
    chk("fwd1_hit", fwd1, 1);
    chk("fwd2_r15", fwd2, 0);
    chk("fwd_data", fwd_data, 32'hCAFE);
`endif

    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(31) == 0, $urandom_range(3) == 0, $urandom_range(7) == 0,
            1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(3) == 0) ? 4'd15 : 4'($urandom), $urandom, $urandom);
`ifdef WB_FWD_EN
      ra1 = 4'($urandom);
      ra2 = ($urandom_range(1) == 0) ? m_wa : 4'($urandom);
`endif
      tick();
    end
    check_model();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
